// File: rtl/rfsoc_config.sv
// Shared configuration for the DAC waveform player: FSM state type and
// gpio_ctrl field positions.
package rfsoc_config;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_PLAY
  } state_t;

  localparam int unsigned CTRL_LOAD    = 0;
  localparam int unsigned CTRL_ARM     = 1;
  localparam int unsigned CTRL_CONT    = 2;
  localparam int unsigned CTRL_CLEAR   = 3;
  localparam int unsigned CTRL_RPT_LSB = 4;

endpackage

// File: rtl/dac_wave_ram.sv
// Simple dual-port waveform store: one write port, one read port with a
// registered output and read enable (holds rdata when re=0).
module dac_wave_ram #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dac_player.sv
// Waveform player: loads words from s_axis into RAM, then replays them on
// m_axis after a selected trigger, for repeat+1 passes or continuously.
module dac_player
  import rfsoc_config::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RPT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       gpio_ctrl,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic              trigger_in,
  input  logic              select_in,
  output logic [ADDR_W:0]   wave_len,
  output logic              busy
);

  state_t            state, state_next;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [RPT_W:0]    pass_cnt;
  logic [RPT_W-1:0]  rpt;
  logic              load_b, arm_b, cont_b, clear_b;
  logic              wr_hs, rd_hs, last, done, play;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_ctrl;

  assign load_b      = gpio_ctrl[CTRL_LOAD];
  assign arm_b       = gpio_ctrl[CTRL_ARM];
  assign cont_b      = gpio_ctrl[CTRL_CONT];
  assign clear_b     = gpio_ctrl[CTRL_CLEAR];
  assign rpt         = gpio_ctrl[CTRL_RPT_LSB +: RPT_W];
  assign unused_ctrl = ^gpio_ctrl;

  assign play          = (state == ST_PLAY);
  assign s_axis_tready = (state == ST_LOAD) && !len_q[ADDR_W];
  assign m_axis_tvalid = play;
  assign m_axis_tdata  = play ? ram_rdata : '0;
  assign busy          = play;
  assign wave_len      = len_q;

  assign wr_hs    = s_axis_tvalid && s_axis_tready;
  assign rd_hs    = m_axis_tvalid && m_axis_tready;
  assign last     = (({1'b0, ptr} + (ADDR_W+1)'(1)) == len_q);
  assign ptr_next = last ? '0 : ptr + ADDR_W'(1);
  assign done     = !arm_b || (!cont_b && (pass_cnt >= {1'b0, rpt}));

  // Read port prefetches: address 0 is kept loaded outside PLAY so the first
  // beat is ready on entry, and in PLAY the next address is fetched on each
  // handshake (wrap included), otherwise rdata is held.
  assign ram_re    = !play || rd_hs;
  assign ram_raddr = play ? ptr_next : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear_b) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (load_b)                       state_next = ST_LOAD;
          else if (arm_b && len_q != '0)    state_next = ST_ARMED;
        end
        ST_LOAD:  if (!load_b)              state_next = ST_IDLE;
        ST_ARMED: begin
          if (!arm_b)                       state_next = ST_IDLE;
          else if (trigger_in && select_in) state_next = ST_PLAY;
        end
        ST_PLAY: begin
          if (rd_hs && last && done)        state_next = arm_b ? ST_ARMED : ST_IDLE;
        end
        default:                            state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      ptr      <= '0;
      pass_cnt <= '0;
    end else if (clear_b) begin
      len_q <= '0;
    end else begin
      if (state == ST_IDLE && load_b) len_q <= '0;
      else if (wr_hs)                 len_q <= len_q + (ADDR_W+1)'(1);

      if (state == ST_ARMED && state_next == ST_PLAY) begin
        ptr      <= '0;
        pass_cnt <= '0;
      end else if (rd_hs) begin
        ptr <= ptr_next;
        if (last && pass_cnt != '1) pass_cnt <= pass_cnt + (RPT_W+1)'(1);
      end
    end
  end

  dac_wave_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_hs),
    .waddr(len_q[ADDR_W-1:0]),
    .wdata(s_axis_tdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_dac_player.sv
// Self-checking bench for dac_player: directed sequences, a control table and
// randomized load/playback checked against a queue-based playback model.
module tb_dac_player;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned RPT_W  = 4;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       gpio_ctrl;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid, s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tready;
  logic              trigger_in, select_in;
  logic [ADDR_W:0]   wave_len;
  logic              busy;

  logic             c_load, c_arm, c_cont, c_clear;
  logic [RPT_W-1:0] c_rpt;

  always_comb begin
    gpio_ctrl = '0;
    gpio_ctrl[0] = c_load;
    gpio_ctrl[1] = c_arm;
    gpio_ctrl[2] = c_cont;
    gpio_ctrl[3] = c_clear;
    gpio_ctrl[4 +: RPT_W] = c_rpt;
  end

  dac_player #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RPT_W(RPT_W)) dut (
    .clk(clk), .rst(rst), .gpio_ctrl(gpio_ctrl),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .trigger_in(trigger_in), .select_in(select_in), .wave_len(wave_len), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] src [16];
  logic [DATA_W-1:0] wave [DEPTH];
  int wave_n = 0;
  logic [DATA_W-1:0] exp_q [$];

  typedef struct {
    logic load, arm, clear, trig, sel;
    logic exp_tready, exp_busy;
    int   exp_len;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enter LOAD, offer n words from src, return how many were accepted.
  task automatic load_words(input int n, output int accepted);
    int w;
    accepted = 0;
    c_load = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src[i];
      w = 0;
      while (!s_axis_tready && w < 5) begin tick(); w++; end
      if (s_axis_tready) begin
        tick();
        accepted++;
        if (accepted == DEPTH) chk("full_tready", s_axis_tready, 0);
      end
    end
    s_axis_tvalid = 1'b0;
    c_load = 1'b0;
    tick();
    wave_n = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < wave_n; i++) wave[i] = src[i];
  endtask

  task automatic arm_up(input logic [RPT_W-1:0] r, input logic cont);
    c_rpt = r; c_cont = cont; c_arm = 1'b1;
    tick();
  endtask

  task automatic build_expect(input int passes);
    exp_q.delete();
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < wave_n; i++) exp_q.push_back(wave[i]);
  endtask

  // Trigger from ARMED and consume exp_q with pct% tready probability.
  task automatic run_play(input int pct, input string tag);
    int cyc, lat;
    logic stalled;
    logic [DATA_W-1:0] held;
    cyc = 0; lat = 0; stalled = 1'b0;
    trigger_in = 1'b1; select_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    while (!m_axis_tvalid && lat < 2) begin tick(); lat++; end
    chk({tag, "_first_valid"}, m_axis_tvalid, 1);
    while (exp_q.size() > 0 && m_axis_tvalid && cyc < 4000) begin
      m_axis_tready = ($urandom_range(99) < pct);
      if (m_axis_tready) chk({tag, "_beat"}, m_axis_tdata, exp_q.pop_front());
      held = m_axis_tdata;
      stalled = !m_axis_tready;
      tick();
      cyc++;
      if (stalled && m_axis_tvalid) chk({tag, "_stall_hold"}, m_axis_tdata, held);
    end
    chk({tag, "_missing_beats"}, exp_q.size(), 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_tvalid_after"}, m_axis_tvalid, 0);
    m_axis_tready = 1'b0;
  endtask

  initial begin
    int acc, nv, beats, cyc, n;
    logic [RPT_W-1:0] r;

    tbl[0]  = '{0,0,0,1,1, 0,0,4};
    tbl[1]  = '{0,1,0,0,0, 0,0,4};
    tbl[2]  = '{0,1,0,1,0, 0,0,4};
    tbl[3]  = '{0,0,0,0,0, 0,0,4};
    tbl[4]  = '{0,1,0,0,0, 0,0,4};
    tbl[5]  = '{0,1,0,1,1, 0,1,4};
    tbl[6]  = '{0,1,0,1,1, 0,1,4};
    tbl[7]  = '{0,1,1,0,0, 0,0,0};
    tbl[8]  = '{0,1,0,0,0, 0,0,0};
    tbl[9]  = '{0,1,0,1,1, 0,0,0};
    tbl[10] = '{1,1,0,0,0, 1,0,0};
    tbl[11] = '{0,0,0,0,0, 0,0,0};

    c_load = 0; c_arm = 0; c_cont = 0; c_clear = 0; c_rpt = '0;
    s_axis_tdata = '0; s_axis_tvalid = 0; m_axis_tready = 0;
    trigger_in = 0; select_in = 0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wave_len", wave_len, 0);
    rst = 1'b0;
    tick();

    // Four lane-replicated words, three passes, then ARMED again.
    for (int i = 0; i < 4; i++) src[i] = {(DATA_W/16){16'(10 + i)}};
    load_words(4, acc);
    chk("load4_accepted", acc, 4);
    chk("load4_len", wave_len, 4);
    arm_up(2, 0);
    build_expect(3);
    run_play(100, "rpt2");
    c_rpt = '0;
    build_expect(1);
    run_play(100, "rearmed");

    // Unselected triggers must not start playback.
    trigger_in = 1'b1; select_in = 1'b0; nv = 0;
    repeat (20) begin tick(); if (m_axis_tvalid) nv++; end
    trigger_in = 1'b0;
    chk("unselected_valid_cycles", nv, 0);

    c_rpt = 4'd3;
    build_expect(4);
    run_play(50, "stall");

    // Continuous mode, arm dropped during pass 2: ends at the second wrap.
    c_cont = 1'b1; c_rpt = '0; m_axis_tready = 1'b1;
    trigger_in = 1'b1; select_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    beats = 0; cyc = 0;
    while (m_axis_tvalid && cyc < 100) begin
      chk("cont_beat", m_axis_tdata, wave[beats % wave_n]);
      beats++;
      tick();
      cyc++;
      if (beats == 5) c_arm = 1'b0;
    end
    chk("cont_total_beats", beats, 8);
    chk("cont_busy_end", busy, 0);
    nv = 0;
    repeat (5) begin tick(); if (m_axis_tvalid) nv++; end
    chk("cont_quiet_after", nv, 0);

    // Reset in the middle of a pass.
    arm_up(0, 1);
    trigger_in = 1'b1; select_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_len", wave_len, 0);
    rst = 1'b0; c_arm = 0; c_cont = 0; m_axis_tready = 0;
    tick();

    // Overfill an 8-deep memory with 10 words.
    for (int i = 0; i < 10; i++) src[i] = $urandom;
    load_words(10, acc);
    chk("full_accepted", acc, 8);
    chk("full_len", wave_len, 8);
    arm_up(0, 0);
    build_expect(1);
    run_play(70, "full");
    c_arm = 1'b0;
    tick();

    // Control table: starts in IDLE with four words stored.
    for (int i = 0; i < 4; i++) src[i] = $urandom;
    load_words(4, acc);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      c_load = tbl[i].load; c_arm = tbl[i].arm; c_clear = tbl[i].clear;
      trigger_in = tbl[i].trig; select_in = tbl[i].sel;
      tick();
      chk($sformatf("tbl%0d_s_tready", i), s_axis_tready, tbl[i].exp_tready);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_tvalid", i), m_axis_tvalid, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_len", i), wave_len, tbl[i].exp_len);
      if (!tbl[i].exp_busy) chk($sformatf("tbl%0d_tdata", i), m_axis_tdata, 0);
    end
    c_load = 0; c_arm = 0; c_clear = 0; trigger_in = 0; select_in = 0;
    tick();

    // Randomized waveforms, repeat counts and back-pressure.
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) src[i] = $urandom;
      load_words(n, acc);
      chk("rand_accepted", acc, n);
      chk("rand_len", wave_len, n);
      r = RPT_W'($urandom_range(0, 3));
      arm_up(r, 0);
      build_expect(int'(r) + 1);
      run_play($urandom_range(30, 100), "rand");
      c_arm = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_player.md
DAC_PLAYER -- requirements
Module: dac_player

Interface
REQ-001 Parameter DATA_W, default 256: AXI-Stream sample word width; a multiple of 16 (16-bit DAC samples per lane).
REQ-002 Parameter ADDR_W, default 16: waveform memory address width; depth = 2**ADDR_W words.
REQ-003 Parameter RPT_W, default 12: repeat-count field width; RPT_W <= 12.
REQ-004 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-005 clk  in  1  sole clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 gpio_ctrl  in  16  control fields: [0] load, [1] arm, [2] continuous, [3] clear, [4+RPT_W-1:4] repeat count.
REQ-008 s_axis_tdata/tvalid/tready  in/in/out  DATA_W/1/1  waveform load stream from PS.
REQ-009 m_axis_tdata/tvalid/tready  out/out/in  DATA_W/1/1  sample stream to RFSoC DAC IP.
REQ-010 trigger_in  in  1  playback start pulse, sampled on clk.
REQ-011 select_in  in  1  channel enable; a trigger counts only when select_in=1 in the same cycle.
REQ-012 wave_len  out  ADDR_W+1  number of words currently stored.
REQ-013 busy  out  1  high in PLAY state.

Function
REQ-014 FSM states: IDLE, LOAD, ARMED, PLAY. No other states are reachable.
REQ-015 IDLE->LOAD when load=1. LOAD->IDLE when load=0.
REQ-016 IDLE->ARMED when arm=1, load=0 and wave_len>0. ARMED->IDLE when arm=0.
REQ-017 ARMED->PLAY on trigger_in&select_in. The first word is valid on m_axis no later than 2 cycles after the trigger cycle.
REQ-018 LOAD: s_axis_tready=1 while wave_len<2**ADDR_W. Each s_axis handshake writes address wave_len, then wave_len increments. Entering LOAD from IDLE resets wave_len to 0.
REQ-019 LOAD, memory full: s_axis_tready=0. Further words are back-pressured and never dropped silently.
REQ-020 s_axis_tready=0 in every state except LOAD.
REQ-021 PLAY: m_axis_tvalid stays 1 and the player reads addresses 0..wave_len-1 in order. The read pointer advances only on an m_axis handshake; tdata holds stable while tready=0.
REQ-022 Wrap: after the handshake of address wave_len-1, the pointer returns to 0 and the pass counter increments. No bubble at the wrap.
REQ-023 Termination:
- continuous=0: PLAY->ARMED (arm=1) or IDLE (arm=0) after the handshake completing pass repeat+1.
- continuous=1: the repeat field is ignored.
- Deasserting arm ends playback at the next wrap.
REQ-024 Outside PLAY: m_axis_tvalid=0 and m_axis_tdata=0.
REQ-025 Triggers are ignored in IDLE, LOAD and PLAY (no queuing).
REQ-026 clear=1 (highest priority, any state): wave_len<=0, state<=IDLE, outputs deasserted next cycle. Memory contents are not erased.
REQ-027 Simultaneous load and arm in IDLE: load wins.
REQ-028 The pass counter is RPT_W+1 bits and never wraps.

Reset
REQ-029 On rst=1 at a clk edge:
- state=IDLE; wave_len=0; pointer and pass counter=0.
- m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, busy=0.
REQ-030 Reset mid-PLAY aborts with no further valid beat. Memory contents are undefined after reset.

Structure
REQ-031 The state enum and the gpio_ctrl bit-position constants live in package rfsoc_config.
REQ-032 Storage is one sub-module, dac_wave_ram: simple dual-port, 1-cycle registered read, inferable as BRAM/URAM.

Verification
REQ-033 Load 4 words (0xA..0xD replicated), arm, repeat=2, trigger with select_in=1 -> 12 beats A,B,C,D x3, then ARMED, busy=0.
REQ-034 Same load, trigger with select_in=0 -> no m_axis_tvalid for 20 cycles.
REQ-035 Playback with tready toggling pseudo-randomly -> identical ordered output, no duplicate or missing words, tdata stable while stalled.
REQ-036 ADDR_W=3, push 10 words -> wave_len=8, s_axis_tready=0 after the 8th handshake, words 9-10 never accepted.
REQ-037 continuous=1, drop arm mid-pass 2 -> the pass completes at the wrap, then IDLE. Assert rst mid-pass -> tvalid=0 the next cycle.
REQ-038 clear=1 during PLAY -> tvalid=0 the next cycle, wave_len=0. A subsequent arm stays in IDLE.
